// File: rtl/lc3Pkg.sv
// Shared LC-3 types and constants for the memory interface: FSM states,
// device register addresses and the device-address decode helper.
package lc3Pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DEV  = 2'd2,
    DONE = 2'd3
  } MemIfStates;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;
  localparam logic [15:0] ADDR_MCR  = 16'hFFFE;

  // Only the five named registers are devices; the rest of xFExx falls through to memory.
  function automatic logic is_dev_addr(input logic [15:0] addr);
    return (addr == ADDR_KBSR) || (addr == ADDR_KBDR) || (addr == ADDR_DSR) ||
           (addr == ADDR_DDR)  || (addr == ADDR_MCR);
  endfunction

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 device registers (KBSR, KBDR, DSR, DDR, MCR) with keyboard/display
// handshakes and the keyboard interrupt request.
module lc3_mmio_regs
  import lc3Pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  input  logic        kbd_valid_i,
  input  logic [7:0]  kbd_data_i,
  output logic        dsp_valid_o,
  output logic [7:0]  dsp_data_o,
  input  logic        dsp_ready_i,
  output logic        kbd_int_o,
  output logic        run_o
);

  logic        kbd_rdy_q, kbd_rdy_d;
  logic        kbd_ie_q, kbd_ie_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        dsp_vld_q, dsp_vld_d;
  logic [7:0]  dsp_data_q, dsp_data_d;
  logic [15:0] mcr_q, mcr_d;

  logic wr_kbsr, rd_kbdr, wr_ddr, wr_mcr;

  assign wr_kbsr = acc_i &  we_i & (addr_i == ADDR_KBSR);
  assign rd_kbdr = acc_i & ~we_i & (addr_i == ADDR_KBDR);
  assign wr_ddr  = acc_i &  we_i & (addr_i == ADDR_DDR);
  assign wr_mcr  = acc_i &  we_i & (addr_i == ADDR_MCR);

  always_comb begin
    kbd_rdy_d  = kbd_rdy_q;
    kbd_ie_d   = kbd_ie_q;
    kbdr_d     = kbdr_q;
    dsp_vld_d  = dsp_vld_q;
    dsp_data_d = dsp_data_q;
    mcr_d      = mcr_q;

    // A keystroke landing on the same cycle as a KBDR read wins, so it is not lost.
    if (rd_kbdr)     kbd_rdy_d = 1'b0;
    if (kbd_valid_i) begin
      kbd_rdy_d = 1'b1;
      kbdr_d    = kbd_data_i;
    end
    if (wr_kbsr) kbd_ie_d = wdata_i[14];

    if (dsp_vld_q && dsp_ready_i) dsp_vld_d = 1'b0;
    if (wr_ddr) begin
      dsp_vld_d  = 1'b1;
      dsp_data_d = wdata_i[7:0];
    end

    if (wr_mcr) mcr_d = wdata_i;
  end

  always_comb begin
    rdata_o = 16'h0000;
    case (addr_i)
      ADDR_KBSR: rdata_o = {kbd_rdy_q, kbd_ie_q, 14'b0};
      ADDR_KBDR: rdata_o = {8'h00, kbdr_q};
      ADDR_DSR:  rdata_o = {~dsp_vld_q, 15'b0};
      ADDR_MCR:  rdata_o = mcr_q;
      default:   rdata_o = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kbd_rdy_q  <= 1'b0;
      kbd_ie_q   <= 1'b0;
      kbdr_q     <= 8'h00;
      dsp_vld_q  <= 1'b0;
      dsp_data_q <= 8'h00;
      mcr_q      <= 16'h8000;
    end else begin
      kbd_rdy_q  <= kbd_rdy_d;
      kbd_ie_q   <= kbd_ie_d;
      kbdr_q     <= kbdr_d;
      dsp_vld_q  <= dsp_vld_d;
      dsp_data_q <= dsp_data_d;
      mcr_q      <= mcr_d;
    end
  end

  assign dsp_valid_o = dsp_vld_q;
  assign dsp_data_o  = dsp_data_q;
  assign kbd_int_o   = kbd_rdy_q & kbd_ie_q;
  assign run_o       = mcr_q[15];

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 memory / MMIO interface: access FSM, fixed-latency external memory port
// and the device register block.
module lc3_mem_if
  import lc3Pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memEN,
  input  logic              memWE,
  input  logic [ADDR_W-1:0] MAR,
  input  logic [15:0]       MDR,
  output logic              memRDY,
  output logic [15:0]       rdata,
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata,
  input  logic              kbd_valid,
  input  logic [7:0]        kbd_data,
  output logic              dsp_valid,
  output logic [7:0]        dsp_data,
  input  logic              dsp_ready,
  output logic              kbd_int,
  output logic              run
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  MemIfStates        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ce_q, ce_d;
  logic [15:0]       rdata_q, rdata_d;
  logic [15:0]       dev_rdata;
  logic              dev_acc;

  assign dev_acc = (state_q == DEV);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ce_d    = 1'b0;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (memEN) begin
          addr_d  = MAR;
          wdata_d = MDR;
          we_d    = memWE;
          cnt_d   = 4'd0;
          if (is_dev_addr(MAR)) begin
            state_d = DEV;
          end else begin
            state_d = MEM;
            ce_d    = 1'b1;
          end
        end
      end
      // Counter runs from the mem_ce cycle; data is sampled once LAT cycles have elapsed.
      MEM: begin
        if (cnt_q == LAT) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DEV: begin
        if (!we_q) rdata_d = dev_rdata;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      ce_q    <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ce_q    <= ce_d;
      rdata_q <= rdata_d;
    end
  end

  assign memRDY    = (state_q == DONE);
  assign rdata     = rdata_q;
  assign mem_ce    = ce_q;
  assign mem_we    = ce_q & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  lc3_mmio_regs u_mmio (
    .clk         (clk),
    .rst         (rst),
    .acc_i       (dev_acc),
    .we_i        (we_q),
    .addr_i      (addr_q),
    .wdata_i     (wdata_q),
    .rdata_o     (dev_rdata),
    .kbd_valid_i (kbd_valid),
    .kbd_data_i  (kbd_data),
    .dsp_valid_o (dsp_valid),
    .dsp_data_o  (dsp_data),
    .dsp_ready_i (dsp_ready),
    .kbd_int_o   (kbd_int),
    .run_o       (run)
  );

endmodule

// File: doc/lc3_mem_if.md
Name: lc3_mem_if

Overview:
Memory and memory-mapped-I/O interface between the LC-3 datapath/control FSM and a synchronous external word memory. Takes MAR, MDR and access requests from the control FSM, runs the external access with fixed latency, and returns read data plus a one-cycle memRDY pulse. Decodes the LC-3 device registers KBSR, KBDR, DSR, DDR and MCR. Generates the keyboard interrupt request that feeds the control FSM's INT input.

Parameters:
MEM_LATENCY, 2, cycles from mem_ce assertion to valid mem_rdata (1..15)
ADDR_W, 16, address width (fixed 16 for LC-3)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
memEN  in  1  access request from control FSM; held until memRDY
memWE  in  1  write qualifier; sampled with memEN at request start
MAR  in  16  access address
MDR  in  16  write data
memRDY  out  1  one-cycle pulse: access complete, rdata valid on reads
rdata  out  16  read data, held until next completed read
mem_ce  out  1  external memory chip enable
mem_we  out  1  external memory write enable
mem_addr  out  16  external address
mem_wdata  out  16  external write data
mem_rdata  in  16  external read data
kbd_valid  in  1  keyboard byte strobe
kbd_data  in  8  keyboard byte
dsp_valid  out  1  display byte valid
dsp_data  out  8  display byte
dsp_ready  in  1  display accepts byte when high with dsp_valid
kbd_int  out  1  KBSR[15] & KBSR[14]
run  out  1  MCR[15]; processor clock-enable

Behaviour:
- Reset values: memRDY=0, rdata=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0, dsp_valid=0, dsp_data=0, KBSR=0, KBDR=0, MCR=x8000 (run=1), kbd_int=0. Reset mid-access aborts it; no memRDY issued.
- Address decode: xFE00 KBSR, xFE02 KBDR, xFE04 DSR, xFE06 DDR, xFFFE MCR are device; all other addresses, including unused xFExx, go to memory.
- FSM states IDLE, MEM, DEV, DONE.
- IDLE: when memEN=1, latch MAR, MDR and memWE.
  - Memory address goes to MEM: assert mem_ce for exactly one cycle, with mem_we=latched WE.
  - Device address goes to DEV.
- MEM: 4-bit counter counts MEM_LATENCY cycles from mem_ce, then:
  - reads capture mem_rdata into rdata;
  - move to DONE.
- DEV: one cycle; performs the register read or write, then moves to DONE.
- DONE: memRDY=1 for one cycle, then IDLE. memEN sampled in IDLE the following cycle may start the next access; there is no back-to-back start from DONE.
- Memory read latency from memEN to memRDY = MEM_LATENCY+2 cycles. Device access latency = 2 cycles.
- KBSR register:
  - bit15 is the ready flag;
  - bit14 is IE, writable;
  - other bits read 0.
- Keyboard input: kbd_valid loads KBDR[7:0]=kbd_data and sets KBSR[15]. An overwrite while ready=1 discards the old byte.
- KBDR read returns {8'h00,KBDR} and clears KBSR[15]. If kbd_valid arrives in the same cycle as the KBDR read, the new byte loads and KBSR[15] stays 1.
- DSR read returns {~dsp_valid,15'b0}.
- DDR write: loads dsp_data=MDR[7:0] and sets dsp_valid. dsp_valid clears on a dsp_valid&dsp_ready cycle. A DDR write while dsp_valid=1 overwrites dsp_data.
- MCR: read/write, full 16 bits; run=MCR[15].
- Writes to read-only fields (KBSR[15], KBDR, DSR) are ignored.
- memEN deasserted mid-access: the access still completes and memRDY still pulses.

Decomposition:
- lc3Pkg gains:
  - typedef MemIfStates {IDLE, MEM, DEV, DONE};
  - localparams ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR, ADDR_MCR.
- One sub-module, lc3_mmio_regs, holds the KBSR/KBDR/DSR/DDR/MCR registers, the keyboard/display handshakes and kbd_int. lc3_mem_if keeps the FSM, latency counter and memory port.

Test Plan:
- MEM_LATENCY=2. Read x3000 with the memory model returning x1234 → mem_ce high for 1 cycle with mem_addr=x3000; memRDY pulses 4 cycles after memEN; rdata=x1234.
- Write x3001 with MDR=xBEEF → single cycle with mem_ce=1, mem_we=1, mem_wdata=xBEEF; memRDY follows; a later read of x3001 returns xBEEF.
- kbd_valid with kbd_data=x41 → read xFE00 gives x8000; read xFE02 gives x0041; read xFE00 again gives x0000.
- Write xFE00=x4000, then kbd_valid → kbd_int=1 the following cycle; read xFE02 → kbd_int=0.
- dsp_ready=0. Write xFE06=x0058 → dsp_valid=1, dsp_data=x58, read xFE04 gives x0000. Raise dsp_ready → dsp_valid=0 next cycle; xFE04 reads x8000.
- Write xFFFE=x0000 → run=0. Assert rst mid-MEM access → no memRDY, all outputs at reset values, run=1.
